// File: rtl/aes_input_buffer.sv
// ---------------------------------------------------------------------------
// aes_input_buffer
//
// Purpose:
//   Word-serial to block-parallel loader in front of the AES core. Host words
//   are collected into a 128-bit key register and a 128-bit text register.
//   Once a full text block is held and a full key is valid, a single-cycle
//   ld_o strobe tells the core to capture text_o/key_o. The first word of a
//   block lands in bits [31:0] and the fourth in [127:96].
//
// Ports:
//   clk          in   1      clock, all state updates on posedge
//   rst          in   1      asynchronous, active-low reset
//   clr_i        in   1      synchronous clear of counters and flags
//   ld_i         in   1      host word valid
//   kt_sel_i     in   1      0 = text word, 1 = key word
//   data_i       in   DW     host word
//   txt_rdy_o    out  1      a text word would be accepted this cycle
//   key_rdy_o    out  1      a key word would be accepted this cycle
//   core_busy_i  in   1      core is processing; holds off issue
//   ld_o         out  1      one-cycle load strobe to the core
//   text_o       out  4*DW   assembled text block
//   key_o        out  4*DW   assembled key
//   key_vld_o    out  1      all key words loaded
// ---------------------------------------------------------------------------
module aes_input_buffer #(
    parameter int DW     = 32,
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 ld_i,
    input  logic                 kt_sel_i,
    input  logic [DW-1:0]        data_i,
    output logic                 txt_rdy_o,
    output logic                 key_rdy_o,
    input  logic                 core_busy_i,
    output logic                 ld_o,
    output logic [NWORDS*DW-1:0] text_o,
    output logic [NWORDS*DW-1:0] key_o,
    output logic                 key_vld_o
);

    localparam int BW = NWORDS * DW;
    localparam int CW = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    logic [BW-1:0] text_q,    text_d;
    logic [BW-1:0] key_q,     key_d;
    logic [CW-1:0] txt_cnt_q, txt_cnt_d;
    logic [CW-1:0] key_cnt_q, key_cnt_d;
    logic          pending_q, pending_d;
    logic          key_vld_q, key_vld_d;
    logic          ld_q,      ld_d;

    logic txt_rdy;
    logic key_rdy;
    logic txt_acc;
    logic key_acc;
    logic issue;

    // A key may still be loaded while text waits on a missing key; only a
    // block that is ready to issue freezes the key register.
    assign txt_rdy = !pending_q;
    assign key_rdy = !(pending_q && key_vld_q);

    assign txt_acc = ld_i && !kt_sel_i && txt_rdy;
    assign key_acc = ld_i &&  kt_sel_i && key_rdy;

    // The !ld_q term keeps the strobe to a single cycle.
    assign issue   = pending_q && key_vld_q && !core_busy_i && !ld_q;

    // NOTE: every next-state signal takes its current value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        text_d    = text_q;
        key_d     = key_q;
        txt_cnt_d = txt_cnt_q;
        key_cnt_d = key_cnt_q;
        pending_d = pending_q;
        key_vld_d = key_vld_q;
        ld_d      = 1'b0;

        if (clr_i) begin
            // Data registers deliberately keep their contents.
            txt_cnt_d = '0;
            key_cnt_d = '0;
            pending_d = 1'b0;
            key_vld_d = 1'b0;
        end else begin
            if (txt_acc) begin
                text_d[DW*txt_cnt_q +: DW] = data_i;
                txt_cnt_d = txt_cnt_q + CW'(1);
                if (txt_cnt_q == LAST) begin
                    pending_d = 1'b1;
                end
            end

            if (key_acc) begin
                key_d[DW*key_cnt_q +: DW] = data_i;
                key_cnt_d = key_cnt_q + CW'(1);
                // Starting a new key invalidates the old one immediately.
                if (key_cnt_q == '0) begin
                    key_vld_d = 1'b0;
                end
                if (key_cnt_q == LAST) begin
                    key_vld_d = 1'b1;
                end
            end

            // Issue cannot coincide with a text accept (txt_rdy is low while
            // pending) nor with a key accept (key_rdy is low once the key is
            // valid), so it never races the updates above.
            if (issue) begin
                ld_d      = 1'b1;
                pending_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data registers are reset too; the core may observe
            // text_o/key_o at any time and must never see X after reset.
            text_q    <= '0;
            key_q     <= '0;
            txt_cnt_q <= '0;
            key_cnt_q <= '0;
            pending_q <= 1'b0;
            key_vld_q <= 1'b0;
            ld_q      <= 1'b0;
        end else begin
            text_q    <= text_d;
            key_q     <= key_d;
            txt_cnt_q <= txt_cnt_d;
            key_cnt_q <= key_cnt_d;
            pending_q <= pending_d;
            key_vld_q <= key_vld_d;
            ld_q      <= ld_d;
        end
    end

    assign txt_rdy_o = txt_rdy;
    assign key_rdy_o = key_rdy;
    assign ld_o      = ld_q;
    assign text_o    = text_q;
    assign key_o     = key_q;
    assign key_vld_o = key_vld_q;

endmodule

// File: tb/tb_aes_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_aes_input_buffer
//
// Self-checking bench for aes_input_buffer: a table of per-cycle vectors for
// the basic key-then-text load, followed by directed sequences for missing
// key, core busy, key reuse/partial reload, async reset and sync clear.
// ---------------------------------------------------------------------------
module tb_aes_input_buffer;

    logic         clk;
    logic         rst;
    logic         clr_i;
    logic         ld_i;
    logic         kt_sel_i;
    logic [31:0]  data_i;
    logic         txt_rdy_o;
    logic         key_rdy_o;
    logic         core_busy_i;
    logic         ld_o;
    logic [127:0] text_o;
    logic [127:0] key_o;
    logic         key_vld_o;

    int tests = 0;
    int fails = 0;

    aes_input_buffer #(.DW(32), .NWORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_i),
        .ld_i        (ld_i),
        .kt_sel_i    (kt_sel_i),
        .data_i      (data_i),
        .txt_rdy_o   (txt_rdy_o),
        .key_rdy_o   (key_rdy_o),
        .core_busy_i (core_busy_i),
        .ld_o        (ld_o),
        .text_o      (text_o),
        .key_o       (key_o),
        .key_vld_o   (key_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        ks;
        logic [31:0] data;
        logic        busy;
        logic        e_ld;
        logic        e_trdy;
        logic        e_krdy;
        logic        e_kvld;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic e_ld, input logic e_trdy,
                               input logic e_krdy, input logic e_kvld);
        check({tag, " ld_o"},      {127'b0, ld_o},      {127'b0, e_ld});
        check({tag, " txt_rdy_o"}, {127'b0, txt_rdy_o}, {127'b0, e_trdy});
        check({tag, " key_rdy_o"}, {127'b0, key_rdy_o}, {127'b0, e_krdy});
        check({tag, " key_vld_o"}, {127'b0, key_vld_o}, {127'b0, e_kvld});
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ks, input logic [31:0] d);
        ld_i     = 1'b1;
        kt_sel_i = ks;
        data_i   = d;
        step();
        ld_i     = 1'b0;
        kt_sel_i = 1'b0;
        data_i   = '0;
    endtask

    task automatic do_reset(input string tag);
        rst         = 1'b0;
        clr_i       = 1'b0;
        ld_i        = 1'b0;
        kt_sel_i    = 1'b0;
        data_i      = '0;
        core_busy_i = 1'b0;
        step();
        check({tag, " text_o"}, text_o, 128'h0);
        check({tag, " key_o"},  key_o,  128'h0);
        check_flags(tag, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step();
    endtask

    initial begin
        // Key 00010203_04050607_08090A0B_0C0D0E0F, least significant word first,
        // then text 0x11..0x44; strobe on the second edge after the 4th word.
        vecs[0] = '{1'b1, 1'b1, 32'h0C0D0E0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h08090A0B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h04050607, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h00010203, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h00000022, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h00000033, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h00000044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // ---- basic load, table driven ----
        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            ld_i        = vecs[i].ld;
            kt_sel_i    = vecs[i].ks;
            data_i      = vecs[i].data;
            core_busy_i = vecs[i].busy;
            step();
            check_flags($sformatf("vec%0d", i), vecs[i].e_ld, vecs[i].e_trdy,
                        vecs[i].e_krdy, vecs[i].e_kvld);
        end
        ld_i = 1'b0;
        check("basic text_o", text_o, 128'h00000044_00000033_00000022_00000011);
        check("basic key_o",  key_o,  128'h00010203_04050607_08090A0B_0C0D0E0F);

        // ---- text before key: waits, key still loadable ----
        do_reset("rst1");
        for (int i = 0; i < 4; i++) send(1'b0, 32'h21 + i);
        check_flags("nokey full", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_flags($sformatf("nokey idle%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) send(1'b1, 32'hA0000000 + i);
        check_flags("key partial", 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 32'hA0000003);
        check_flags("key done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check_flags("late issue", 1'b1, 1'b1, 1'b1, 1'b1);
        check("late text_o", text_o, 128'h00000024_00000023_00000022_00000021);
        check("late key_o",  key_o,  128'hA0000003_A0000002_A0000001_A0000000);
        step();
        check_flags("late after", 1'b0, 1'b1, 1'b1, 1'b1);

        // ---- core busy holds the block; extra words are refused ----
        core_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h51 + i);
        check_flags("busy full", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ld_i     = 1'b1;
            kt_sel_i = 1'b0;
            data_i   = 32'hDEADBEEF;
            step();
            check_flags($sformatf("busy hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        ld_i = 1'b0;
        check("busy text_o", text_o, 128'h00000054_00000053_00000052_00000051);
        core_busy_i = 1'b0;
        step();
        check_flags("busy release", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check_flags("busy after", 1'b0, 1'b1, 1'b1, 1'b1);

        // ---- second block reuses the key ----
        for (int i = 0; i < 4; i++) send(1'b0, 32'h61 + i);
        step();
        check_flags("reuse issue", 1'b1, 1'b1, 1'b1, 1'b1);
        check("reuse text_o", text_o, 128'h00000064_00000063_00000062_00000061);
        check("reuse key_o",  key_o,  128'hA0000003_A0000002_A0000001_A0000000);
        step();

        // ---- partial new key invalidates, block does not issue ----
        send(1'b1, 32'hB0000000);
        check_flags("newkey w0", 1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b1, 32'hB0000001);
        check("newkey key_o", key_o, 128'hA0000003_A0000002_B0000001_B0000000);
        for (int i = 0; i < 4; i++) send(1'b0, 32'h71 + i);
        check_flags("newkey full", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_flags($sformatf("newkey idle%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // ---- async reset mid-block ----
        do_reset("rst2");
        send(1'b0, 32'h81);
        send(1'b0, 32'h82);
        check("pre-rst text_o", text_o, 128'h00000000_00000000_00000082_00000081);
        rst = 1'b0;
        #2;
        check("async text_o", text_o, 128'h0);
        check("async key_o",  key_o,  128'h0);
        check_flags("async", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send(1'b0, 32'h91 + i);
        check("post-rst text_o", text_o, 128'h00000094_00000093_00000092_00000091);
        check_flags("post-rst", 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- sync clear after 3 text words ----
        do_reset("rst3");
        for (int i = 0; i < 4; i++) send(1'b1, 32'hC0000000 + i);
        send(1'b0, 32'hE1);
        send(1'b0, 32'hE2);
        send(1'b0, 32'hE3);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check_flags("clr", 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr key_o",  key_o,  128'hC0000003_C0000002_C0000001_C0000000);
        check("clr text_o", text_o, 128'h00000000_000000E3_000000E2_000000E1);
        send(1'b0, 32'hF1);
        check("clr next text_o", text_o, 128'h00000000_000000E3_000000E2_000000F1);
        check_flags("clr next", 1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
